// File: rtl/rv_trace_buf.sv
// rtl/rv_trace_buf.sv - retirement-trace capture buffer with PC/external trigger and valid/ready readout
// Define RV_TRACE_MEM_EN to store memory address/data with each record.
module rv_trace_buf #(
   parameter int DEPTH = 64
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_ret_valid,
   input  logic [29:0]               i_ret_pc,
   input  logic [31:0]               i_ret_instr,
   input  logic                      i_ret_reg_write,
   input  logic [31:0]               i_ret_reg_data,
   input  logic                      i_ret_mem_write,
   input  logic                      i_ret_mem_read,
`ifdef RV_TRACE_MEM_EN
   input  logic [31:0]               i_ret_mem_addr,
   input  logic [31:0]               i_ret_mem_data,
`endif
   input  logic                      i_arm,
   input  logic                      i_trig_en,
   input  logic [29:0]               i_trig_pc,
   input  logic                      i_ext_trig,
   input  logic [$clog2(DEPTH)-1:0]  i_post_count,
   output logic [1:0]                o_state,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic [$clog2(DEPTH)-1:0]  o_trig_pos,
   output logic                      o_rd_valid,
   input  logic                      i_rd_ready,
   output logic [29:0]               o_rd_pc,
   output logic [31:0]               o_rd_instr,
   output logic [31:0]               o_rd_reg_data,
   output logic [2:0]                o_rd_flags,
   output logic [31:0]               o_rd_mem_addr,
   output logic [31:0]               o_rd_mem_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic [PTR_W-1:0] rem;
   logic [PTR_W-1:0] post_loaded;
   logic [PTR_W:0]   rd_left;

   logic [29:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic [31:0] data_mem  [DEPTH];
   logic [2:0]  flag_mem  [DEPTH];
`ifdef RV_TRACE_MEM_EN
   logic [31:0] maddr_mem [DEPTH];
   logic [31:0] mdata_mem [DEPTH];
`endif

   logic             capture;
   logic             pc_hit;
   logic             trig_fire;
   logic             rd_fire;
   logic [PTR_W-1:0] wp_inc;
   logic [PTR_W-1:0] wp_new;
   logic [PTR_W-1:0] rem_load;
   logic [PTR_W:0]   count_inc;
   logic [PTR_W:0]   count_after;
   logic [PTR_W:0]   count_m1;

   // count_after is the record count including this cycle's write; an external
   // trigger without a retire points at the newest record already held.
   always_comb begin
      capture     = i_ret_valid && !i_arm && (state == S_ARMED || state == S_POST);
      pc_hit      = i_ret_valid && i_trig_en && (i_ret_pc == i_trig_pc);
      trig_fire   = (state == S_ARMED) &&
                    (pc_hit || (i_ext_trig && (i_ret_valid || o_count != '0)));
      rd_fire     = o_rd_valid && i_rd_ready;
      wp_inc      = wp + 1'b1;
      wp_new      = i_ret_valid ? wp_inc : wp;
      count_inc   = (o_count == FULL) ? o_count : o_count + 1'b1;
      count_after = i_ret_valid ? count_inc : o_count;
      count_m1    = count_after - 1'b1;
      rem_load    = ({1'b0, i_post_count} < count_m1) ? i_post_count : count_m1[PTR_W-1:0];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= S_IDLE;
         wp          <= '0;
         rp          <= '0;
         rem         <= '0;
         post_loaded <= '0;
         rd_left     <= '0;
         o_count     <= '0;
         o_trig_pos  <= '0;
      end else if (i_arm) begin
         state       <= S_ARMED;
         wp          <= '0;
         rp          <= '0;
         rem         <= '0;
         post_loaded <= '0;
         rd_left     <= '0;
         o_count     <= '0;
         o_trig_pos  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
            end
            S_ARMED: begin
               if (i_ret_valid) begin
                  wp      <= wp_inc;
                  o_count <= count_inc;
               end
               if (trig_fire) begin
                  rem         <= rem_load;
                  post_loaded <= rem_load;
                  if (rem_load == '0) begin
                     state      <= S_DONE;
                     o_trig_pos <= PTR_W'(count_after - 1'b1);
                     rp         <= PTR_W'(wp_new - count_after);
                     rd_left    <= count_after;
                  end else begin
                     state <= S_POST;
                  end
               end
            end
            S_POST: begin
               if (i_ret_valid) begin
                  wp      <= wp_inc;
                  o_count <= count_inc;
                  rem     <= rem - 1'b1;
                  if (rem == PTR_W'(1)) begin
                     state      <= S_DONE;
                     o_trig_pos <= PTR_W'(count_inc - 1'b1 - {1'b0, post_loaded});
                     rp         <= PTR_W'(wp_inc - count_inc);
                     rd_left    <= count_inc;
                  end
               end
            end
            S_DONE: begin
               if (rd_fire) begin
                  rp      <= rp + 1'b1;
                  rd_left <= rd_left - 1'b1;
                  if (rd_left == (PTR_W+1)'(1)) begin
                     state   <= S_IDLE;
                     o_count <= '0;
                  end
               end
            end
         endcase
      end
   end

   // Buffer contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (capture) begin
         pc_mem[wp]    <= i_ret_pc;
         instr_mem[wp] <= i_ret_instr;
         data_mem[wp]  <= i_ret_reg_data;
         flag_mem[wp]  <= {i_ret_reg_write, i_ret_mem_write, i_ret_mem_read};
`ifdef RV_TRACE_MEM_EN
         maddr_mem[wp] <= i_ret_mem_addr;
         mdata_mem[wp] <= i_ret_mem_data;
`endif
      end
   end

   assign o_state       = state;
   assign o_rd_valid    = (state == S_DONE) && (rd_left != '0);
   assign o_rd_pc       = pc_mem[rp];
   assign o_rd_instr    = instr_mem[rp];
   assign o_rd_reg_data = data_mem[rp];
   assign o_rd_flags    = flag_mem[rp];
`ifdef RV_TRACE_MEM_EN
   assign o_rd_mem_addr = maddr_mem[rp];
   assign o_rd_mem_data = mdata_mem[rp];
`else
   assign o_rd_mem_addr = 32'd0;
   assign o_rd_mem_data = 32'd0;
`endif

endmodule
